conv_shape_calc: RTL

//  Consumes the CONV configuration fields from regfile_interface (data/filter dims, stride, padding).

---
 rtl/conv_shape_calc.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/conv_shape_calc.sv
// Validates conv geometry and computes output width/height with one shared restoring divider.
// Latency: start edge 0 -> done after edge 36 (edge 2 on param_err). Start is ignored while busy.
module conv_shape_calc #(
    parameter int DIM_W = 16,
    parameter int STR_W = 8,
    parameter int PAD_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DIM_W-1:0] data_wid,
    input  logic [DIM_W-1:0] data_hei,
    input  logic [DIM_W-1:0] data_ch,
    input  logic [DIM_W-1:0] filter_wid,
    input  logic [DIM_W-1:0] filter_hei,
    input  logic [STR_W-1:0] stride_horiz,
    input  logic [STR_W-1:0] stride_vert,
    input  logic [PAD_W-1:0] padding_horiz,
    input  logic [PAD_W-1:0] padding_vert,
    output logic [DIM_W-1:0] out_data_wid,
    output logic [DIM_W-1:0] out_data_hei,
    output logic [DIM_W-1:0] filter_ch,
    output logic [3:0]       status,
    output logic             done
);
    localparam int NW = DIM_W + 2;
    localparam int QW = DIM_W + 1;
    localparam int CW = $clog2(QW);
    localparam logic [CW-1:0] LAST = CW'(QW - 1);

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_DIV_H, S_DIV_V, S_FINISH} state_t;
    state_t state_q, state_d;

    logic [DIM_W-1:0] dw_q, dh_q, fw_q, fh_q;
    logic [STR_W-1:0] sh_q, sv_q;
    logic [PAD_W-1:0] ph_q, pv_q;
    logic [QW-1:0]    div_q, qh_q;
    logic [STR_W-1:0] rem_q;
    logic [CW-1:0]    cnt_q;
    logic [DIM_W-1:0] owid_q, ohei_q, fch_q;
    logic [3:0]       status_q;
    logic             done_q;

    logic [NW-1:0]    padded_w, padded_h;
    logic [QW-1:0]    nh, nv;
    logic             param_err;
    logic [STR_W-1:0] divisor, rem_sub, rem_step;
    logic [STR_W:0]   rem_sh;
    logic             q_bit;
    logic [QW-1:0]    div_step;
    logic [QW:0]      out_w_full, out_h_full;
    logic             ovf_w, ovf_h;

    // Span the kernel can slide over; only meaningful when param_err is low.
    assign padded_w  = NW'(dw_q) + NW'({ph_q, 1'b0});
    assign padded_h  = NW'(dh_q) + NW'({pv_q, 1'b0});
    assign nh        = QW'(padded_w - NW'(fw_q));
    assign nv        = QW'(padded_h - NW'(fh_q));
    assign param_err = (fw_q == '0) || (fh_q == '0) || (sh_q == '0) || (sv_q == '0)
                    || (NW'(fw_q) > padded_w) || (NW'(fh_q) > padded_h);

    // Remainder stays below the divisor, so STR_W bits hold it between steps.
    always_comb begin
        divisor  = (state_q == S_DIV_V) ? sv_q : sh_q;
        rem_sh   = {rem_q, div_q[QW-1]};
        rem_sub  = rem_sh[STR_W-1:0] - divisor;
        q_bit    = (rem_sh >= {1'b0, divisor});
        rem_step = q_bit ? rem_sub : rem_sh[STR_W-1:0];
        div_step = {div_q[QW-2:0], q_bit};
    end

    assign out_w_full = (QW+1)'(qh_q) + (QW+1)'(1);
    assign out_h_full = (QW+1)'(div_q) + (QW+1)'(1);
    assign ovf_w      = |out_w_full[QW:DIM_W];
    assign ovf_h      = |out_h_full[QW:DIM_W];

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_CHECK;
            S_CHECK:  state_d = param_err ? S_FINISH : S_DIV_H;
            S_DIV_H:  if (cnt_q == LAST) state_d = S_DIV_V;
            S_DIV_V:  if (cnt_q == LAST) state_d = S_FINISH;
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dw_q <= '0; dh_q <= '0; fw_q <= '0; fh_q <= '0;
            sh_q <= '0; sv_q <= '0; ph_q <= '0; pv_q <= '0;
            div_q <= '0; qh_q <= '0; rem_q <= '0; cnt_q <= '0;
            owid_q <= '0; ohei_q <= '0; fch_q <= '0;
            status_q <= '0; done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: if (start) begin
                    dw_q <= data_wid;     dh_q <= data_hei;
                    fw_q <= filter_wid;   fh_q <= filter_hei;
                    sh_q <= stride_horiz; sv_q <= stride_vert;
                    ph_q <= padding_horiz; pv_q <= padding_vert;
                    fch_q    <= data_ch;
                    status_q <= 4'b0001;
                end
                S_CHECK: begin
                    if (param_err) begin
                        status_q[2] <= 1'b1;
                    end else begin
                        div_q <= nh;
                        rem_q <= '0;
                        cnt_q <= '0;
                    end
                end
                S_DIV_H: begin
                    if (cnt_q == LAST) begin
                        qh_q  <= div_step;
                        div_q <= nv;
                        rem_q <= '0;
                        cnt_q <= '0;
                    end else begin
                        div_q <= div_step;
                        rem_q <= rem_step;
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_DIV_V: begin
                    div_q <= div_step;
                    rem_q <= rem_step;
                    cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
                end
                S_FINISH: begin
                    if (status_q[2]) begin
                        owid_q <= '0;
                        ohei_q <= '0;
                    end else begin
                        owid_q      <= ovf_w ? '1 : out_w_full[DIM_W-1:0];
                        ohei_q      <= ovf_h ? '1 : out_h_full[DIM_W-1:0];
                        status_q[3] <= ovf_w | ovf_h;
                    end
                    status_q[1] <= 1'b1;
                    status_q[0] <= 1'b0;
                    done_q      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign out_data_wid = owid_q;
    assign out_data_hei = ohei_q;
    assign filter_ch    = fch_q;
    assign status       = status_q;
    assign done         = done_q;
endmodule
